// File: rtl/ws2812_chain.sv
// WS2812 daisy-chain driver: streams NUM_LEDS GRB words MSB-first as NRZ pulses, framed by a
// leading and a trailing latch-low period. A one-entry buffer lets the next pixel arrive while
// the current one is still shifting out, so consecutive pixels run without a gap.
module ws2812_chain #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned T0H      = 9,
  parameter int unsigned T0L      = 20,
  parameter int unsigned T1H      = 20,
  parameter int unsigned T1L      = 9,
  parameter int unsigned T_RESET  = 13500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        sout
);

  localparam int unsigned TMaxA = (T0H > T0L) ? T0H : T0L;
  localparam int unsigned TMaxB = (T1H > T1L) ? T1H : T1L;
  localparam int unsigned TMaxC = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned TMax  = (TMaxC > T_RESET) ? TMaxC : T_RESET;
  localparam int unsigned CntW  = $clog2(TMax + 1);
  localparam int unsigned LedW  = $clog2(NUM_LEDS + 1);

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [CntW-1:0] T0HEnd    = CntW'(T0H - 1);
  localparam logic [CntW-1:0] T0LEnd    = CntW'(T0L - 1);
  localparam logic [CntW-1:0] T1HEnd    = CntW'(T1H - 1);
  localparam logic [CntW-1:0] T1LEnd    = CntW'(T1L - 1);
  localparam logic [CntW-1:0] TResetEnd = CntW'(T_RESET - 1);
  localparam logic [LedW-1:0] NumLeds   = LedW'(NUM_LEDS);

  typedef enum logic [2:0] {StIdle, StPre, StHigh, StLow, StLatch} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [LedW-1:0]   acc_q, acc_d;
  logic [LedW-1:0]   sent_q, sent_d;
  logic              flag_q, flag_d;
  logic              sout_q, sout_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;
  logic              load;
  logic              xfer;

  assign busy       = (state_q != StIdle);
  assign pix_ready  = busy && !buf_full_q && (acc_q < NumLeds);
  assign xfer       = pix_valid && pix_ready;
  assign sout       = sout_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // Sequencer: phase timing, bit/pixel progression and shifter reloads.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CntW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    sent_d       = sent_q;
    flag_d       = flag_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StPre;
          sent_d  = '0;
          flag_d  = 1'b0;
        end
      end
      StPre: begin
        if (cnt_q == TResetEnd) begin
          cnt_d = '0;
          if (buf_full_q) begin
            load    = 1'b1;
            state_d = StHigh;
          end else begin
            flag_d  = 1'b1;
            state_d = StLatch;
          end
        end
      end
      StHigh: begin
        if (cnt_q == (shift_q[23] ? T1HEnd : T0HEnd)) begin
          cnt_d   = '0;
          state_d = StLow;
        end
      end
      StLow: begin
        if (cnt_q == (shift_q[23] ? T1LEnd : T0LEnd)) begin
          cnt_d = '0;
          if (bit_q == 5'd23) begin
            sent_d = sent_q + LedW'(1);
            if (sent_q + LedW'(1) == NumLeds) begin
              state_d = StLatch;
            end else if (buf_full_q) begin
              load    = 1'b1;
              state_d = StHigh;
            end else begin
              flag_d  = 1'b1;
              state_d = StLatch;
            end
          end else begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            state_d = StHigh;
          end
        end
      end
      StLatch: begin
        if (cnt_q == TResetEnd) begin
          cnt_d        = '0;
          state_d      = StIdle;
          frame_done_d = 1'b1;
          underrun_d   = flag_q;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      shift_d = buf_q;
      bit_d   = '0;
    end
  end

  // Prefetch buffer and accepted-pixel count; the line follows the state being entered.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q && !load;
    acc_d      = acc_q;
    if (state_q == StIdle) begin
      buf_full_d = 1'b0;
      if (start) begin
        acc_d = '0;
      end
    end
    if (xfer) begin
      buf_d      = pix_data;
      buf_full_d = 1'b1;
      acc_d      = acc_q + LedW'(1);
    end
    sout_d = (state_d == StHigh);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      acc_q        <= '0;
      sent_q       <= '0;
      flag_q       <= 1'b0;
      sout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      acc_q        <= acc_d;
      sent_q       <= sent_d;
      flag_q       <= flag_d;
      sout_q       <= sout_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain: accepted pixels go into a scoreboard queue; a line decoder rebuilds
// words from sout pulse widths, checks every phase length, and pops/compares each word.
module tb_ws2812_chain;

  localparam int unsigned NumLeds = 2;
  localparam int unsigned T0H     = 2;
  localparam int unsigned T0L     = 4;
  localparam int unsigned T1H     = 4;
  localparam int unsigned T1L     = 2;
  localparam int unsigned TReset  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic        sout;

  int n_tests = 0;
  int n_fail  = 0;

  ws2812_chain #(
    .NUM_LEDS(NumLeds),
    .T0H     (T0H),
    .T0L     (T0L),
    .T1H     (T1H),
    .T1L     (T1L),
    .T_RESET (TReset)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun),
    .sout      (sout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard fed on every handshake edge.
  logic [23:0] sb_q[$];
  int          frame_acc = 0;

  always @(posedge clk) begin
    if (!rst && pix_valid && pix_ready) begin
      sb_q.push_back(pix_data);
      frame_acc++;
    end
  end

  // Line decoder state.
  logic        exp_unr    = 1'b0;
  logic        prev_sout  = 1'b0;
  logic        have_bit   = 1'b0;
  logic        last_bit   = 1'b0;
  logic [23:0] word       = '0;
  int          nbits      = 0;
  int          high_run   = 0;
  int          low_run    = 0;
  int          busy_cnt   = 0;
  int          bit_cycles = 0;
  int          late_ready = 0;
  int          done_cnt   = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      frame_acc = 0; prev_sout = 1'b0; have_bit = 1'b0; nbits = 0; word = '0;
      high_run = 0; low_run = 0; busy_cnt = 0; bit_cycles = 0; late_ready = 0;
    end else begin
      if (busy) busy_cnt++;
      if (pix_ready && frame_acc >= NumLeds) late_ready++;
      if (frame_done || underrun) check_eq("done_pulse", frame_done, 1'b1);
      if (sout) begin
        if (!prev_sout) begin
          if (have_bit) check_eq("low_len", low_run, last_bit ? T1L : T0L);
          else          check_eq("pre_len", low_run, TReset);
          low_run = 0;
        end
        high_run++;
      end else begin
        if (prev_sout) begin
          check_eq("high_len", (high_run == T0H) || (high_run == T1H), 1'b1);
          last_bit   = (high_run == T1H);
          have_bit   = 1'b1;
          word       = {word[22:0], last_bit};
          bit_cycles += last_bit ? (T1H + T1L) : (T0H + T0L);
          nbits++;
          if (nbits == 24) begin
            if (sb_q.size() == 0) check_eq("sb_has_word", 0, 1);
            else                  check_eq("pixel", word, sb_q.pop_front());
            nbits = 0;
          end
          high_run = 0;
          low_run  = 0;
        end
        if (busy) low_run++;
      end
      if (frame_done) begin
        done_cnt++;
        check_eq("tail_len", low_run, (last_bit ? T1L : T0L) + TReset);
        check_eq("underrun", underrun, exp_unr);
        check_eq("busy_cycles", busy_cnt, 2 * TReset + bit_cycles);
        check_eq("accepted", frame_acc, exp_unr ? 1 : NumLeds);
        check_eq("late_ready", late_ready, 0);
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("partial_bits", nbits, 0);
        frame_acc = 0; have_bit = 1'b0; busy_cnt = 0; bit_cycles = 0; late_ready = 0;
        low_run = 0;
      end
      if (!busy) low_run = 0;
      prev_sout = sout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [23:0] d);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    while (!pix_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check_eq("hs_timeout", 0, 1);
    tick();
    pix_valid = 1'b0;
    pix_data  = 24'h0;
  endtask

  task automatic wait_rises(input int count);
    int n = 0;
    int seen = 0;
    logic p = sout;
    while (seen < count && n < 2000) begin
      tick();
      if (sout && !p) seen++;
      p = sout;
      n++;
    end
    if (n >= 2000) check_eq("rise_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check_eq("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int d0;
    repeat (3) tick();
    check_eq("rst_sout", sout, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", pix_ready, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_unr", underrun, 1'b0);
    rst = 1'b0;
    tick();

    // Basic frame, both pixels offered as soon as possible.
    exp_unr = 1'b0;
    pulse_start();
    send_pix(24'hFF0000);
    send_pix(24'h000001);
    wait_done();
    repeat (3) tick();

    // Second pixel arrives late, during bit 5 of the first.
    pulse_start();
    send_pix(24'hA5C3F0);
    wait_rises(6);
    send_pix(24'h5A3C0F);
    wait_done();
    repeat (3) tick();

    // Underrun: only one pixel supplied.
    exp_unr = 1'b1;
    pulse_start();
    send_pix(24'h123456);
    wait_done();
    exp_unr = 1'b0;
    repeat (3) tick();

    // Start while busy is ignored; extra data is never accepted.
    d0 = done_cnt;
    pulse_start();
    send_pix(24'h0F0F0F);
    wait_rises(10);
    pulse_start();
    send_pix(24'hF0F0F0);
    pix_valid = 1'b1;
    pix_data  = 24'hDEADBE;
    pulse_start();
    wait_done();
    pix_valid = 1'b0;
    repeat (30) tick();
    check_eq("one_done", done_cnt - d0, 1);
    check_eq("idle_after", busy, 1'b0);

    // Reset in the middle of a high phase.
    pulse_start();
    send_pix(24'hFFFFFF);
    send_pix(24'h800000);
    wait_rises(3);
    rst = 1'b1;
    tick();
    check_eq("mrst_sout", sout, 1'b0);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_ready", pix_ready, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    check_eq("mrst_quiet", sout, 1'b0);
    pulse_start();
    send_pix(24'h00FF00);
    send_pix(24'h0000FF);
    wait_done();
    repeat (3) tick();

    // Valid held high while the data keeps changing.
    pulse_start();
    pix_valid = 1'b1;
    for (int i = 0; i < 2000 && frame_acc < NumLeds; i++) begin
      pix_data = 24'($urandom);
      tick();
    end
    pix_valid = 1'b0;
    check_eq("stream_accepts", frame_acc, NumLeds);
    wait_done();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
